// File: rtl/fft4_stream_if.sv
// Sample/bin stream bundle between the environment and fft4_stream_ctrl.
// The master drives samples in and accepts bins out; the slave is the controller.
interface fft4_stream_if;
   logic               s_valid;
   logic               s_ready;
   logic signed [31:0] s_re;
   logic signed [31:0] s_im;
   logic               m_valid;
   logic               m_ready;
   logic signed [34:0] m_re;
   logic signed [34:0] m_im;
   logic [1:0]         m_idx;
   logic               m_last;

   modport master (
      output s_valid, s_re, s_im, m_ready,
      input  s_ready, m_valid, m_re, m_im, m_idx, m_last
   );

   modport slave (
      input  s_valid, s_re, s_im, m_ready,
      output s_ready, m_valid, m_re, m_im, m_idx, m_last
   );
endinterface

// File: rtl/fft4_stream_ctrl.sv
// Streaming controller around the 4-point FFT core: gathers samples into
// frames, launches them, tracks the core's fixed latency with a token delay
// line, captures results into a 2-frame buffer and replays them as bins.
// At most two frames are ever in flight or buffered, so a capture always
// finds a free buffer slot.
module fft4_stream_ctrl #(
   parameter int FFT_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   fft4_stream_if.slave       io,
   output logic signed [31:0] fft_in1,
   output logic signed [31:0] fft_in2,
   output logic signed [31:0] fft_in3,
   output logic signed [31:0] fft_in4,
   output logic signed [31:0] fft_in1i,
   output logic signed [31:0] fft_in2i,
   output logic signed [31:0] fft_in3i,
   output logic signed [31:0] fft_in4i,
   input  logic signed [34:0] fft_out1,
   input  logic signed [34:0] fft_out2,
   input  logic signed [34:0] fft_out3,
   input  logic signed [34:0] fft_out4,
   input  logic signed [34:0] fft_out1i,
   input  logic signed [34:0] fft_out2i,
   input  logic signed [34:0] fft_out3i,
   input  logic signed [34:0] fft_out4i,
   output logic               busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // staging area and launch registers
   logic [2:0]             fill_q, fill_d;
   logic [2:0]             fill_base;
   logic [3:0][31:0]       stg_re_q, stg_re_d, stg_im_q, stg_im_d;
   logic [3:0][31:0]       fin_re_q, fin_re_d, fin_im_q, fin_im_d;

   // latency tracking and frame accounting
   logic [FFT_LAT-1:0]     dl_q, dl_d;
   logic [1:0]             infl_q, infl_d;
   logic [1:0]             bcnt_q, bcnt_d;
   logic [1:0]             credits;
   logic                   wr_q, wr_d, rd_q, rd_d;

   // result buffer: [frame][bin]
   logic [1:0][3:0][34:0]  res_re_q, res_re_d, res_im_q, res_im_d;

   // drain FSM
   state_t                 state_q, state_d;
   logic [1:0]             idx_q, idx_d;

   logic                   launch;
   logic                   accept;
   logic                   capture;
   logic                   m_valid_int;
   logic                   drain;

   assign credits     = infl_q + bcnt_q;
   assign launch      = (fill_q == 3'd4) && (credits < 2'd2);
   assign io.s_ready  = !rst && ((fill_q < 3'd4) || launch);
   assign accept      = io.s_valid && io.s_ready;
   assign capture     = dl_q[FFT_LAT-1];
   assign m_valid_int = (state_q == ST_SEND);
   assign drain       = m_valid_int && io.m_ready && (idx_q == 2'd3);

   assign io.m_valid  = m_valid_int;
   assign io.m_re     = res_re_q[rd_q][idx_q];
   assign io.m_im     = res_im_q[rd_q][idx_q];
   assign io.m_idx    = idx_q;
   assign io.m_last   = m_valid_int && (idx_q == 2'd3);
   assign busy        = (fill_q != 3'd0) || (infl_q != 2'd0) || (bcnt_q != 2'd0);

   assign fft_in1  = fin_re_q[0];
   assign fft_in2  = fin_re_q[1];
   assign fft_in3  = fin_re_q[2];
   assign fft_in4  = fin_re_q[3];
   assign fft_in1i = fin_im_q[0];
   assign fft_in2i = fin_im_q[1];
   assign fft_in3i = fin_im_q[2];
   assign fft_in4i = fin_im_q[3];

   // Gather samples; a launch frees the stage first, flush drops everything
   // still being gathered (a coinciding launch has already taken its frame).
   always_comb begin
      stg_re_d  = stg_re_q;
      stg_im_d  = stg_im_q;
      fill_base = launch ? 3'd0 : fill_q;
      fill_d    = fill_base;
      if (flush) begin
         fill_d = 3'd0;
      end else if (accept) begin
         stg_re_d[fill_base[1:0]] = io.s_re;
         stg_im_d[fill_base[1:0]] = io.s_im;
         fill_d                   = fill_base + 3'd1;
      end else begin
         fill_d = fill_base;
      end
   end

   // Core input registers load the staged frame on launch and hold otherwise.
   always_comb begin
      fin_re_d = fin_re_q;
      fin_im_d = fin_im_q;
      if (launch) begin
         fin_re_d = stg_re_q;
         fin_im_d = stg_im_q;
      end else begin
         fin_re_d = fin_re_q;
         fin_im_d = fin_im_q;
      end
   end

   // Token delay line, frame counters, pointers and result capture.
   always_comb begin
      dl_d    = dl_q;
      dl_d[0] = launch;
      for (int i = 1; i < FFT_LAT; i++) begin
         dl_d[i] = dl_q[i-1];
      end
      infl_d   = infl_q + {1'b0, launch} - {1'b0, capture};
      bcnt_d   = bcnt_q + {1'b0, capture} - {1'b0, drain};
      wr_d     = capture ? !wr_q : wr_q;
      rd_d     = drain ? !rd_q : rd_q;
      res_re_d = res_re_q;
      res_im_d = res_im_q;
      if (capture) begin
         res_re_d[wr_q] = {fft_out4, fft_out3, fft_out2, fft_out1};
         res_im_d[wr_q] = {fft_out4i, fft_out3i, fft_out2i, fft_out1i};
      end else begin
         res_re_d = res_re_q;
         res_im_d = res_im_q;
      end
   end

   // Drain FSM: enters SEND as soon as a frame is captured so bin 0 is
   // presented the cycle after capture, and chains frames without a bubble.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bcnt_d != 2'd0) begin
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (io.m_ready) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = (bcnt_d != 2'd0) ? ST_SEND : ST_IDLE;
               end else begin
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Datapath and accounting registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q   <= 3'd0;
         stg_re_q <= '0;
         stg_im_q <= '0;
         fin_re_q <= '0;
         fin_im_q <= '0;
         dl_q     <= '0;
         infl_q   <= 2'd0;
         bcnt_q   <= 2'd0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         res_re_q <= '0;
         res_im_q <= '0;
      end else begin
         fill_q   <= fill_d;
         stg_re_q <= stg_re_d;
         stg_im_q <= stg_im_d;
         fin_re_q <= fin_re_d;
         fin_im_q <= fin_im_d;
         dl_q     <= dl_d;
         infl_q   <= infl_d;
         bcnt_q   <= bcnt_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         res_re_q <= res_re_d;
         res_im_q <= res_im_d;
      end
   end

   // Drain FSM state and bin index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Scoreboard bench for fft4_stream_ctrl with a behavioural FFT core model.
module tb_fft4_stream_ctrl;

   typedef struct packed {
      logic signed [34:0] re;
      logic signed [34:0] im;
      logic [1:0]         idx;
   } bin_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic busy;
   logic signed [31:0] fin_re[4];
   logic signed [31:0] fin_im[4];
   logic signed [34:0] core_re[4];
   logic signed [34:0] core_im[4];

   fft4_stream_if ifc ();

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_hs_cyc = 0;
   int   stall_acc = 0;
   bit   rand_mr = 1'b0;
   logic mr_dir = 1'b1;
   bin_t exp_q[$];
   logic signed [31:0] fr_re[4];
   logic signed [31:0] fr_im[4];

   fft4_stream_ctrl #(.FFT_LAT(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .io(ifc),
      .fft_in1(fin_re[0]), .fft_in2(fin_re[1]), .fft_in3(fin_re[2]), .fft_in4(fin_re[3]),
      .fft_in1i(fin_im[0]), .fft_in2i(fin_im[1]), .fft_in3i(fin_im[2]), .fft_in4i(fin_im[3]),
      .fft_out1(core_re[0]), .fft_out2(core_re[1]), .fft_out3(core_re[2]), .fft_out4(core_re[3]),
      .fft_out1i(core_im[0]), .fft_out2i(core_im[1]), .fft_out3i(core_im[2]), .fft_out4i(core_im[3]),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic signed [34:0] sx(input logic signed [31:0] v);
      return {{3{v[31]}}, v};
   endfunction

   // core model: butterflies registered once, sampled by the controller 2 edges after launch
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            core_re[k] <= '0;
            core_im[k] <= '0;
         end
      end else begin
         core_re[0] <= sx(fin_re[0]) + sx(fin_re[1]) + sx(fin_re[2]) + sx(fin_re[3]);
         core_im[0] <= sx(fin_im[0]) + sx(fin_im[1]) + sx(fin_im[2]) + sx(fin_im[3]);
         core_re[1] <= sx(fin_re[0]) + sx(fin_im[1]) - sx(fin_re[2]) - sx(fin_im[3]);
         core_im[1] <= sx(fin_im[0]) - sx(fin_re[1]) - sx(fin_im[2]) + sx(fin_re[3]);
         core_re[2] <= sx(fin_re[0]) - sx(fin_re[1]) + sx(fin_re[2]) - sx(fin_re[3]);
         core_im[2] <= sx(fin_im[0]) - sx(fin_im[1]) + sx(fin_im[2]) - sx(fin_im[3]);
         core_re[3] <= sx(fin_re[0]) - sx(fin_im[1]) - sx(fin_re[2]) + sx(fin_im[3]);
         core_im[3] <= sx(fin_im[0]) + sx(fin_re[1]) - sx(fin_im[2]) - sx(fin_re[3]);
      end
   end

   // m_ready driver: directed level or random
   initial begin
      ifc.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ifc.m_ready = rand_mr ? 1'($urandom_range(0, 1)) : mr_dir;
      end
   end

   task automatic chk_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_bin(input longint re, input longint im, input int k);
      bin_t b;
      b.re  = 35'(re);
      b.im  = 35'(im);
      b.idx = 2'(k);
      exp_q.push_back(b);
   endtask

   // reference DFT: Y[k] = sum x[n] * (-j)^(n*k)
   task automatic push_ref();
      for (int k = 0; k < 4; k++) begin
         longint ar = 0;
         longint ai = 0;
         for (int n = 0; n < 4; n++) begin
            longint xr = longint'(fr_re[n]);
            longint xi = longint'(fr_im[n]);
            case ((n * k) % 4)
               0: begin ar += xr; ai += xi; end
               1: begin ar += xi; ai -= xr; end
               2: begin ar -= xr; ai -= xi; end
               3: begin ar -= xi; ai += xr; end
               default: ;
            endcase
         end
         push_bin(ar, ai, k);
      end
   endtask

   task automatic load(input logic signed [31:0] r0, input logic signed [31:0] r1,
                       input logic signed [31:0] r2, input logic signed [31:0] r3,
                       input logic signed [31:0] i0, input logic signed [31:0] i1,
                       input logic signed [31:0] i2, input logic signed [31:0] i3);
      fr_re[0] = r0; fr_re[1] = r1; fr_re[2] = r2; fr_re[3] = r3;
      fr_im[0] = i0; fr_im[1] = i1; fr_im[2] = i2; fr_im[3] = i3;
   endtask

   task automatic send(input logic signed [31:0] re, input logic signed [31:0] im);
      bit hs = 1'b0;
      int n = 0;
      ifc.s_valid = 1'b1;
      ifc.s_re    = re;
      ifc.s_im    = im;
      while (!hs && n < 300) begin
         @(negedge clk);
         hs = ifc.s_ready;
         if (hs) last_hs_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      ifc.s_valid = 1'b0;
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no s_ready expected handshake within 300 cycles");
      end
      stall_acc += n - 1;
   endtask

   task automatic send_frame(input bit gaps);
      for (int n = 0; n < 4; n++) begin
         if (gaps) begin
            int g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
         end
         send(fr_re[n], fr_im[n]);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk_eq("drain_pending_bins", exp_q.size(), 0);
      chk_eq("drain_busy", busy, 0);
   endtask

   // monitor: scoreboard compare on every handshake, hold check under backpressure
   bit   prev_stall = 1'b0;
   bin_t prev_bin;
   always @(negedge clk) begin
      bin_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!ifc.m_valid || ifc.m_re != prev_bin.re || ifc.m_im != prev_bin.im || ifc.m_idx != prev_bin.idx) begin
               errors++;
               $display("FAIL hold: got v=%0b re=%0d im=%0d idx=%0d expected v=1 re=%0d im=%0d idx=%0d",
                        ifc.m_valid, ifc.m_re, ifc.m_im, ifc.m_idx, prev_bin.re, prev_bin.im, prev_bin.idx);
            end
         end
         if (ifc.m_valid && ifc.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_bin: got re=%0d im=%0d idx=%0d expected no bin", ifc.m_re, ifc.m_im, ifc.m_idx);
            end else begin
               e = exp_q.pop_front();
               if (ifc.m_re != e.re || ifc.m_im != e.im || ifc.m_idx != e.idx || ifc.m_last != (e.idx == 2'd3)) begin
                  errors++;
                  $display("FAIL bin: got re=%0d im=%0d idx=%0d last=%0b expected re=%0d im=%0d idx=%0d last=%0b",
                           ifc.m_re, ifc.m_im, ifc.m_idx, ifc.m_last, e.re, e.im, e.idx, (e.idx == 2'd3));
               end
            end
         end
         prev_stall   = ifc.m_valid && !ifc.m_ready;
         prev_bin.re  = ifc.m_re;
         prev_bin.im  = ifc.m_im;
         prev_bin.idx = ifc.m_idx;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int run;
      ifc.s_valid = 1'b0;
      ifc.s_re    = '0;
      ifc.s_im    = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_s_ready", ifc.s_ready, 0);
      chk_eq("rst_m_valid", ifc.m_valid, 0);
      chk_eq("rst_m_re", ifc.m_re, 0);
      chk_eq("rst_m_idx", ifc.m_idx, 0);
      chk_eq("rst_m_last", ifc.m_last, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_fft_in1", fin_re[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_eq("s_ready_after_rst", ifc.s_ready, 1);

      // single frame (0,1,2,3) with latency check
      mr_dir = 1'b1;
      @(posedge clk); #1;
      push_bin(6, 0, 0); push_bin(-2, 2, 1); push_bin(-2, 0, 2); push_bin(-2, -2, 3);
      load(0, 1, 2, 3, 0, 0, 0, 0);
      send_frame(1'b0);
      for (int i = 0; i < 20 && !ifc.m_valid; i++) @(negedge clk);
      chk_eq("first_bin_latency", cyc - last_hs_cyc, 4);
      wait_drain(100);

      // back-to-back frames: no s_ready stall, gap-free output
      push_bin(2, 0, 0); push_bin(1, -1, 1); push_bin(0, 0, 2); push_bin(1, 1, 3);
      push_bin(0, 0, 0); push_bin(2, 0, 1); push_bin(0, 0, 2); push_bin(2, 0, 3);
      stall_acc = 0;
      run = 0;
      fork
         begin
            load(1, 1, 0, 0, 0, 0, 0, 0);
            send_frame(1'b0);
            load(1, 0, -1, 0, 0, 0, 0, 0);
            send_frame(1'b0);
         end
         begin
            for (int i = 0; i < 40 && !ifc.m_valid; i++) @(negedge clk);
            while (ifc.m_valid && run < 20) begin
               run++;
               @(negedge clk);
            end
         end
      join
      chk_eq("b2b_s_ready_stalls", stall_acc, 0);
      chk_eq("b2b_m_valid_run", run, 8);
      wait_drain(100);

      // backpressure: three frames with m_ready low
      mr_dir = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      load(10, 20, 30, 40, -1, -2, -3, -4);            push_ref(); send_frame(1'b0);
      load(7, -7, 100, 0, 3, 3, 3, 3);                 push_ref(); send_frame(1'b0);
      load(32'sh7fff_ffff, 32'sh8000_0000, -5, 9, 32'sh7fff_ffff, 32'sh7fff_ffff, 0, -1);
      push_ref(); send_frame(1'b0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk_eq("bp_s_ready_low", ifc.s_ready, 0);
      chk_eq("bp_m_valid", ifc.m_valid, 1);
      chk_eq("bp_bin0_re", ifc.m_re, 100);
      chk_eq("bp_busy", busy, 1);
      mr_dir = 1'b1;
      wait_drain(200);

      // flush of a partial frame, then a clean frame
      send(100, 200);
      send(300, 400);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      load(0, 1, 2, 3, 0, 0, 0, 0);
      push_ref();
      send_frame(1'b0);
      wait_drain(100);

      // flush coincident with launch keeps the frame
      load(5, 6, 7, 8, -8, 4, 0, 1);
      push_ref();
      send_frame(1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_drain(100);

      // reset with one frame buffered and one in flight
      mr_dir = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      load(1, 2, 3, 4, 5, 6, 7, 8);       push_ref(); send_frame(1'b0);
      load(-1, -2, -3, -4, 9, 9, 9, 9);   push_ref(); send_frame(1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk_eq("mid_rst_m_valid", ifc.m_valid, 0);
      chk_eq("mid_rst_s_ready", ifc.s_ready, 0);
      chk_eq("mid_rst_busy", busy, 0);
      chk_eq("mid_rst_m_re", ifc.m_re, 0);
      chk_eq("mid_rst_m_im", ifc.m_im, 0);
      chk_eq("mid_rst_fft_in4i", fin_im[3], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      mr_dir = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_eq("post_rst_no_output", ifc.m_valid, 0);
      chk_eq("post_rst_s_ready", ifc.s_ready, 1);

      // random frames with random s_valid gaps and random m_ready
      rand_mr = 1'b1;
      for (int f = 0; f < 200; f++) begin
         load($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         push_ref();
         send_frame(1'b1);
      end
      rand_mr = 1'b0;
      wait_drain(2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
